// File: rtl/e_muldiv_pkg.sv
// Shared constants for the multiply/divide path.
// The MulDivOp encoding below is shared by the D-stage controller, the
// hazard unit and the E-stage multiply/divide unit.
//   muldiv_op_e     : 4-bit operation code carried down the pipeline
//   MD_CNT_W        : width of the latency down-counter
//   is_muldiv_start : true for the ops that launch a multi-cycle operation
package e_muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } muldiv_op_e;

  localparam int MD_CNT_W = 4;

  function automatic logic is_muldiv_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit; owns the HI/LO registers.
// The result is computed in the start cycle and held in pending registers
// until the fixed latency expires, then committed to HI/LO.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   req            : exception/interrupt flush of the op in E
//   E_MulDivOp     : operation code (muldiv_op_e; 9-15 act as NOP)
//   E_RS, E_RT     : operands A (dividend / MT source) and B (divisor)
//   E_MulDiv_Start : combinational, an op is being accepted this cycle
//   E_MulDiv_Busy  : registered, an operation is in flight
//   E_MulDiv_Out   : combinational HI (MFHI) / LO (MFLO), else 0
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  E_MulDivOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_MulDiv_Start,
  output logic        E_MulDiv_Busy,
  output logic [31:0] E_MulDiv_Out
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         pend_hi_q, pend_hi_d;
  logic [31:0]         pend_lo_q, pend_lo_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic                start;
  logic                idle_ok;
  logic                rt_zero;
  logic signed [63:0]  mul_s;
  logic [63:0]         mul_u;
  logic signed [32:0]  div_a, div_b, quo_s, rem_s;
  logic [31:0]         div_den_u, quo_u, rem_u;

  assign idle_ok = !req && !busy_q;
  assign start   = is_muldiv_start(E_MulDivOp) && idle_ok;
  assign rt_zero = (E_RT == 32'd0);

  // Signed divide runs at 33 bits so that 0x80000000 / -1 yields +2^31,
  // whose low 32 bits are the architecturally expected 0x80000000.
  // A zero divisor is replaced by 1 only to keep the operators defined;
  // that result is never committed.
  always_comb begin
    mul_s     = $signed({{32{E_RS[31]}}, E_RS}) * $signed({{32{E_RT[31]}}, E_RT});
    mul_u     = {32'd0, E_RS} * {32'd0, E_RT};
    div_a     = $signed({E_RS[31], E_RS});
    div_b     = rt_zero ? 33'sd1 : $signed({E_RT[31], E_RT});
    quo_s     = div_a / div_b;
    rem_s     = div_a % div_b;
    div_den_u = rt_zero ? 32'd1 : E_RT;
    quo_u     = E_RS / div_den_u;
    rem_u     = E_RS % div_den_u;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == MD_CNT_W'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      case (E_MulDivOp)
        MD_MULT: begin
          {pend_hi_d, pend_lo_d} = mul_s;
          cnt_d = MULT_CNT;
        end
        MD_MULTU: begin
          {pend_hi_d, pend_lo_d} = mul_u;
          cnt_d = MULT_CNT;
        end
        MD_DIV: begin
          // Divide by zero commits the current HI/LO back unchanged; HI/LO
          // cannot be written while busy, so this snapshot stays valid.
          pend_hi_d = rt_zero ? hi_q : rem_s[31:0];
          pend_lo_d = rt_zero ? lo_q : quo_s[31:0];
          cnt_d     = DIV_CNT;
        end
        default: begin
          pend_hi_d = rt_zero ? hi_q : rem_u;
          pend_lo_d = rt_zero ? lo_q : quo_u;
          cnt_d     = DIV_CNT;
        end
      endcase
    end else if (idle_ok) begin
      if (E_MulDivOp == MD_MTHI) hi_d = E_RS;
      if (E_MulDivOp == MD_MTLO) lo_d = E_RS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign E_MulDiv_Start = start;
  assign E_MulDiv_Busy  = busy_q;

  // MF* presented while busy is a hazard-contract violation and reads 0.
  assign E_MulDiv_Out = busy_q                   ? 32'd0 :
                        (E_MulDivOp == MD_MFHI)  ? hi_q  :
                        (E_MulDivOp == MD_MFLO)  ? lo_q  : 32'd0;

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv: hand-computed HI/LO results, busy length,
// req suppression, divide-by-zero hold, async reset mid-divide and
// back-to-back issue.
module tb_e_muldiv;
  import e_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        start;
  logic        busy;
  logic [31:0] out;

  int n_chk  = 0;
  int n_fail = 0;

  e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .E_MulDivOp    (op),
    .E_RS          (rs),
    .E_RT          (rt),
    .E_MulDiv_Start(start),
    .E_MulDiv_Busy (busy),
    .E_MulDiv_Out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Combinational read of HI/LO through MFHI/MFLO in the current cycle.
  task automatic rd(input logic [3:0] mf, input logic [31:0] exp, input string tag);
    op = mf;
    #1;
    chk(tag, out, exp);
    op = MD_NOP;
  endtask

  task automatic mt(input logic [3:0] mop, input logic [31:0] val);
    chk("contract_mt", busy, 0);
    op = mop;
    rs = val;
    step();
    op = MD_NOP;
  endtask

  // Issue a mult/div, count busy cycles, optionally pulse req at busy
  // cycle req_at (0 = never). Returns at the first non-busy cycle.
  task automatic issue(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cycles, input int req_at, input string tag);
    int n;
    chk({tag, "_contract"}, busy, 0);
    op = mop;
    rs = a;
    rt = b;
    #1;
    chk({tag, "_start"}, start, 1);
    step();
    op = MD_NOP;
    n = 0;
    while (busy && n < 40) begin
      n++;
      req = (n == req_at);
      step();
    end
    req = 1'b0;
    chk({tag, "_busy_cycles"}, n, exp_cycles);
  endtask

  initial begin
    rst = 1'b0;
    req = 1'b0;
    op  = MD_NOP;
    rs  = '0;
    rt  = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    rd(MD_MFHI, 32'h0, "rst_hi");
    rd(MD_MFLO, 32'h0, "rst_lo");
    step();
    rst = 1'b1;
    step();

    // Signed MULT: -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0, "mult");
    rd(MD_MFLO, 32'hFFFF_FFFA, "mult_lo");
    rd(MD_MFHI, 32'hFFFF_FFFF, "mult_hi");
    step();

    // Signed DIV: -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, "div");
    rd(MD_MFLO, 32'hFFFF_FFFD, "div_lo");
    rd(MD_MFHI, 32'hFFFF_FFFF, "div_hi");

    // Overflow corner: 0x80000000 / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, "divovf");
    rd(MD_MFLO, 32'h8000_0000, "divovf_lo");
    rd(MD_MFHI, 32'h0, "divovf_hi");

    // Unsigned DIVU 100 / 7
    issue(MD_DIVU, 32'd100, 32'd7, 10, 0, "divu");
    rd(MD_MFLO, 32'd14, "divu_lo");
    rd(MD_MFHI, 32'd2, "divu_hi");

    // DIVU by zero leaves preloaded HI/LO
    mt(MD_MTHI, 32'h1234_5678);
    mt(MD_MTLO, 32'h1234_5678);
    rd(MD_MFHI, 32'h1234_5678, "mt_hi");
    issue(MD_DIVU, 32'd5, 32'd0, 10, 0, "div0");
    rd(MD_MFHI, 32'h1234_5678, "div0_hi");
    rd(MD_MFLO, 32'h1234_5678, "div0_lo");

    // req in the same cycle as MULTU: suppressed
    op  = MD_MULTU;
    rs  = 32'hFFFF_FFFF;
    rt  = 32'hFFFF_FFFF;
    req = 1'b1;
    #1;
    chk("req_start", start, 0);
    step();
    chk("req_busy", busy, 0);
    req = 1'b0;
    op  = MD_NOP;
    step();
    chk("req_busy2", busy, 0);
    rd(MD_MFHI, 32'h1234_5678, "req_hi");
    rd(MD_MFLO, 32'h1234_5678, "req_lo");

    // req at busy cycle 3 does not abort
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 3, "multu");
    rd(MD_MFHI, 32'hFFFF_FFFE, "multu_hi");
    rd(MD_MFLO, 32'h0000_0001, "multu_lo");

    // MTLO with req high is suppressed
    op  = MD_MTLO;
    rs  = 32'hDEAD_BEEF;
    req = 1'b1;
    step();
    req = 1'b0;
    op  = MD_NOP;
    rd(MD_MFLO, 32'h0000_0001, "mtreq_lo");

    // Async reset at busy cycle 4 of a DIV
    chk("rstdiv_contract", busy, 0);
    op = MD_DIV;
    rs = 32'd100;
    rt = 32'd7;
    step();
    op = MD_NOP;
    step();
    step();
    step();
    chk("rstdiv_busy_pre", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstdiv_busy", busy, 0);
    rd(MD_MFHI, 32'h0, "rstdiv_hi");
    rd(MD_MFLO, 32'h0, "rstdiv_lo");
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("rstdiv_busy_after", busy, 0);
    rd(MD_MFHI, 32'h0, "rstdiv_hi_after");
    rd(MD_MFLO, 32'h0, "rstdiv_lo_after");

    // Back-to-back: MULT 2x3 then MTLO 7 at first non-busy cycle
    issue(MD_MULT, 32'd2, 32'd3, 5, 0, "b2b");
    rd(MD_MFLO, 32'd6, "b2b_mult_lo");
    mt(MD_MTLO, 32'd7);
    rd(MD_MFLO, 32'd7, "b2b_lo");
    rd(MD_MFHI, 32'd0, "b2b_hi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e_muldiv.md
# e_muldiv

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It consumes the operands and `E_MulDivOp` delivered by the D→E pipeline register and owns the HI/LO architectural registers. Multi-cycle mult/div operations run for a fixed latency, reported through `busy`/`start` to the hazard unit. Instructions cancelled by an exception/interrupt request (`req`) are suppressed.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: reset, asynchronous, active-low. Asserting it clears all state immediately.
- `req  in  1`: exception/interrupt flush; the instruction currently in E is cancelled.
- `E_MulDivOp  in  4`: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9–15 treated as NOP.
- `E_RS  in  32`: operand A (dividend / MTHI-MTLO source).
- `E_RT  in  32`: operand B (divisor).
- `E_MulDiv_Start  out  1`: combinational. High when op ∈ {1..4}, `req`=0 and `busy`=0.
- `E_MulDiv_Busy  out  1`: registered. High while an operation is in flight.
- `E_MulDiv_Out  out  32`: combinational. HI for MFHI, LO for MFLO, else 0.

## Operation
- **State**
  - HI, LO (32 each).
  - pending HI/LO (32 each).
  - counter (4 bits, must hold `DIV_CYCLES`).
  - busy.
- **Reset values:** all zero, so every output reads 0 (`E_MulDiv_Out` is 0 for any op while HI=LO=0).
- **Accepted start** (`E_MulDiv_Start`=1): latch the result into the pending registers, load counter with `MULT_CYCLES` or `DIV_CYCLES`, set busy.
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient, truncated toward zero; HI = remainder, sign of dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: the operation runs its full latency, but HI/LO are left unchanged at commit.
- **While busy:** counter decrements each cycle. On the cycle counter==1, pending is committed to HI/LO and busy clears at the same edge.
- **MTHI/MTLO:** with `req`=0 and busy=0, write `E_RS` to HI/LO at the clock edge.
- **`req` rules**
  - `req`=1 suppresses any start, MTHI or MTLO in that cycle.
  - `req` arriving while busy does NOT abort: the operation was accepted earlier and is committed.
- **Hazard contract**
  - The hazard unit stalls any mult/div/mf/mt in D while `Start|Busy`.
  - An op 1–8 presented to E while busy is a contract violation. RTL ignores it (no state change, `E_MulDiv_Out`=0 for MF*). The bench asserts it never occurs.
- **Reset mid-operation:** busy, counter and pending drop to 0 immediately. HI/LO clear. No commit happens.

## Timing
- Start sampled at edge T.
  - Busy is high for cycles T+1 … T+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO hold the new values from cycle T+N+1, when busy is low.
- An MFHI/MFLO in E at T+N+1 returns the new value; `E_MulDiv_Out` follows HI/LO combinationally.
- MTHI/MTLO: new value visible the cycle after the write.
- Back-to-back: a new start is accepted at cycle T+N+1, the first cycle busy is low.

## Structure
- The MulDivOp encoding (values 0–8) belongs in the shared constants header, also used by the D-stage controller and hazard unit.
- No sub-module. Arithmetic uses the `*`, `/` and `%` operators on `$signed`/unsigned operands at start time. A single always block holds HI/LO/pending/counter/busy; continuous assigns drive Start and Out.

## Test plan
- **Signed MULT:** RS=0xFFFFFFFE (−2), RT=3. Busy high for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO the next cycle outputs 0xFFFFFFFA.
- **Signed DIV:** RS=0xFFFFFFF9 (−7), RT=2. Busy high for exactly 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIVU by zero:** HI=LO=0x12345678 preloaded via MTHI/MTLO, then DIVU RS=5, RT=0. Busy runs 10 cycles; HI/LO are still 0x12345678 afterwards.
- **req with MULTU in E:** RS=RT=0xFFFFFFFF with `req`=1 in the same cycle. Start=0, busy never rises, HI/LO unchanged. Then `req` pulses at busy cycle 3 of an accepted MULTU with the same operands: completion still gives HI=0xFFFFFFFE, LO=0x00000001.
- **Reset at busy cycle 4 of a DIV:** `rst` low asynchronously. Busy=0, HI=LO=0 immediately, with no late commit after `rst` releases.
- **Back-to-back:** MULT (2×3) then MTLO 7 presented at the first non-busy cycle. LO=7 and HI=0 the following cycle.
